// File: rtl/arm_pkg.sv
// Shared definitions for the ARM multicycle controller: FSM state encoding,
// datapath mux/ALU encodings, instruction class and cond/cmd field codes.
package arm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_UNDEF  = 4'd10
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1 = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_logic.sv
// Flags register {N,Z,C,V} and condition evaluation. CondEx is sampled once
// per instruction (cond_latch, asserted in DECODE) against the registered
// flags, so a same-cycle flags update never affects the evaluation.
module cond_logic
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic       flags_wr_nz,
    input  logic       flags_wr_cv,
    output logic       cond_ex
);

    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;
    logic       cond_now;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;
    assign cond_ex = condex_q;

    // Evaluate the cond field against the current (old) flags
    always_comb begin
        cond_now = 1'b0;
        case (cond)
            COND_EQ: cond_now = z_flag;
            COND_NE: cond_now = ~z_flag;
            COND_CS: cond_now = c_flag;
            COND_CC: cond_now = ~c_flag;
            COND_MI: cond_now = n_flag;
            COND_PL: cond_now = ~n_flag;
            COND_VS: cond_now = v_flag;
            COND_VC: cond_now = ~v_flag;
            COND_HI: cond_now = c_flag & ~z_flag;
            COND_LS: cond_now = ~c_flag | z_flag;
            COND_GE: cond_now = (n_flag == v_flag);
            COND_LT: cond_now = (n_flag != v_flag);
            COND_GT: cond_now = ~z_flag & (n_flag == v_flag);
            COND_LE: cond_now = z_flag | (n_flag != v_flag);
            COND_AL: cond_now = 1'b1;
            COND_NV: cond_now = 1'b0;
            default: cond_now = 1'b0;
        endcase
    end

    // Next CondEx and flags: updates only happen for executed instructions
    always_comb begin
        condex_d = cond_latch ? cond_now : condex_q;
        flags_d  = flags_q;
        if (flags_wr_nz && condex_q) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (flags_wr_cv && condex_q) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    // Flags and CondEx registers, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: main FSM plus output/ALU decode.
// Optional feature: define ARM_CMP_EN to execute CMP (cmd 1010, S=1) as a
// flag-setting SUB with no register write; otherwise it is an unsupported cmd.
module arm_mc_controller
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    state_e     state_q, state_d;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       is_imm, s_bit, rd_is_pc;
    logic       cond_ex, cond_latch, flags_wr_nz, flags_wr_cv, in_exec;
    logic [1:0] dp_alu_ctrl;
    logic       dp_reg_wr, dp_nz_upd, dp_cv_upd;
    logic       unused_bits;

    assign op       = Instruction[27:26];
    assign is_imm   = Instruction[25];
    assign cmd      = Instruction[24:21];
    assign s_bit    = Instruction[20];   // also the L bit for memory ops
    assign rd_is_pc = (Instruction[15:12] == 4'hF);
    assign unused_bits = ^{Instruction[19:16], Instruction[11:0]};

    assign State       = state_q;
    assign in_exec     = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign cond_latch  = (state_q == S_DECODE);
    assign flags_wr_nz = in_exec && dp_nz_upd;
    assign flags_wr_cv = in_exec && dp_cv_upd;

    cond_logic u_cond_logic (
        .clk         (clk),
        .rst         (rst),
        .cond        (Instruction[31:28]),
        .alu_flags   (ALUFlags),
        .cond_latch  (cond_latch),
        .flags_wr_nz (flags_wr_nz),
        .flags_wr_cv (flags_wr_cv),
        .cond_ex     (cond_ex)
    );

    // Data-processing cmd decode: ALU op, register write and flag-update classes
    always_comb begin
        dp_alu_ctrl = ALU_ADD;
        dp_reg_wr   = 1'b0;
        dp_nz_upd   = 1'b0;
        dp_cv_upd   = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_alu_ctrl = ALU_ADD; dp_reg_wr = 1'b1; dp_nz_upd = s_bit; dp_cv_upd = s_bit; end
            CMD_SUB: begin dp_alu_ctrl = ALU_SUB; dp_reg_wr = 1'b1; dp_nz_upd = s_bit; dp_cv_upd = s_bit; end
            CMD_AND: begin dp_alu_ctrl = ALU_AND; dp_reg_wr = 1'b1; dp_nz_upd = s_bit; end
            CMD_ORR: begin dp_alu_ctrl = ALU_ORR; dp_reg_wr = 1'b1; dp_nz_upd = s_bit; end
            CMD_CMP: begin
`ifdef ARM_CMP_EN
                if (s_bit) begin
                    dp_alu_ctrl = ALU_SUB;
                    dp_nz_upd   = 1'b1;
                    dp_cv_upd   = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state outputs; reset forces every output low at once
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_DP;
        ALUControl = ALU_ADD;
        RegSrc     = {(op == OP_MEM) && !s_bit, (op == OP_BR)};
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM:   state_d = S_MEMADR;
                    OP_DP:    state_d = is_imm ? S_EXECI : S_EXECR;
                    OP_BR:    state_d = S_BRANCH;
                    OP_UNDEF: state_d = S_UNDEF;
                    default:  state_d = S_UNDEF;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
                state_d = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_ex;
                PCWrite   = cond_ex && rd_is_pc;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = dp_alu_ctrl;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu_ctrl;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = cond_ex && dp_reg_wr;
                PCWrite  = cond_ex && dp_reg_wr && rd_is_pc;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALURESULT;
                PCWrite   = cond_ex;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (!rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = 2'b00;
            RegSrc     = 2'b00;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: a table of directed instructions with
// hand-derived state sequences, a reset-during-MEMRD sequence, and random
// instructions, all checked cycle by cycle against an instruction-level model.
module tb_arm_mc_controller;

`ifdef ARM_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;
    logic [16:0] ctl_obs;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_flags;   // model flags {N,Z,C,V}

    typedef struct packed { logic [3:0] st; logic [16:0] ctl; } cyc_t;
    cyc_t exp_q[$];

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  af;
        logic [19:0] sts;   // one hex digit per visited state, first state most significant
        int          len;
        logic        pcw, rw, mw;   // write enables seen in the last cycle
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Instruction(Instruction),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    assign ctl_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    function automatic logic [16:0] pk(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] res, sa, sb, imm, rs, alu);
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, rs, alu};
    endfunction

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 0=ADD 1=SUB 2=AND 3=ORR 4=CMP, -1 = unsupported cmd
    function automatic int dp_kind(input logic [3:0] cmd, input logic s);
        if (cmd == 4'b1010 && s && CMP_EN) return 4;
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            default: return -1;
        endcase
    endfunction

    // Expected per-cycle state/control sequence of one instruction
    task automatic build_expect(input logic [31:0] ins, output bit ok, output int kind);
        logic [1:0] rs, op, alu;
        bit rd15, wr;
        op   = ins[27:26];
        ok   = cond_pass(ins[31:28], m_flags);
        kind = (op == 2'b00) ? dp_kind(ins[24:21], ins[20]) : -1;
        rs   = {op == 2'b01 && !ins[20], op == 2'b10};
        rd15 = (ins[15:12] == 4'hF);
        alu  = (kind == 4) ? 2'b01 : (kind < 0) ? 2'b00 : 2'(kind);
        wr   = ok && kind >= 0 && kind <= 3;
        exp_q.delete();
        exp_q.push_back({4'd0, pk(1, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00, rs, 2'b00)});
        exp_q.push_back({4'd1, pk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, rs, 2'b00)});
        case (op)
            2'b01: begin
                exp_q.push_back({4'd2, pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, rs, 2'b00)});
                if (ins[20]) begin
                    exp_q.push_back({4'd3, pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, rs, 2'b00)});
                    exp_q.push_back({4'd4, pk(ok && rd15, 0, 0, 0, ok, 2'b01, 2'b00, 2'b00, 2'b00, rs, 2'b00)});
                end else begin
                    exp_q.push_back({4'd5, pk(0, 1, ok, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, rs, 2'b00)});
                end
            end
            2'b00: begin
                if (ins[25])
                    exp_q.push_back({4'd7, pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, rs, alu)});
                else
                    exp_q.push_back({4'd6, pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, rs, alu)});
                exp_q.push_back({4'd8, pk(wr && rd15, 0, 0, 0, wr, 2'b00, 2'b00, 2'b00, 2'b00, rs, 2'b00)});
            end
            2'b10: exp_q.push_back({4'd9, pk(ok, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b10, rs, 2'b00)});
            default: exp_q.push_back({4'd10, pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, rs, 2'b00)});
        endcase
    endtask

    // Run one instruction from its FETCH cycle; called at a falling edge.
    // stop_at >= 0 returns right after checking that cycle (no flags update).
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] af,
                             input int stop_at, output logic [19:0] sts, output int len,
                             output logic pcw, output logic rw, output logic mw);
        bit ok;
        int kind;
        build_expect(ins, ok, kind);
        sts = '0; len = 0; pcw = 0; rw = 0; mw = 0;
        Instruction = ins;
        ALUFlags    = af;
        foreach (exp_q[k]) begin
            #1;
            checks++;
            if ({State, ctl_obs} !== exp_q[k]) begin
                errors++;
                $display("FAIL %s ins=%08h cycle %0d: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                         tag, ins, k, State, ctl_obs, exp_q[k].st, exp_q[k].ctl);
            end
            sts = {sts[15:0], State};
            len++;
            pcw = PCWrite; rw = RegWrite; mw = MemWrite;
            if (k == stop_at) return;
            @(negedge clk);
        end
        if (ok && kind == 4) begin
            m_flags = af;
        end else if (ok && kind >= 0 && ins[20]) begin
            m_flags[3:2] = af[3:2];
            if (kind <= 1) m_flags[1:0] = af[1:0];
        end
        $display("instr %-8s ins=%08h flags_in=%h cycles=%0d model_flags=%h", tag, ins, af, len, m_flags);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({State, ctl_obs} !== 21'h0) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%05h, want state=0 ctl=00000", tag, State, ctl_obs);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] sts;
        int          len;
        logic        pcw, rw, mw;
        logic [31:0] ins;
        logic [3:0]  cmds [5];

        tbl[0]  = '{32'hE2821005, 4'b0000, 20'h00178, 4, 0, 1, 0};  // ADD R1,R2,#5
        tbl[1]  = '{32'hE5921004, 4'b0000, 20'h01234, 5, 0, 1, 0};  // LDR
        tbl[2]  = '{32'hE2521001, 4'b0110, 20'h00178, 4, 0, 1, 0};  // SUBS -> Z=1
        tbl[3]  = '{32'h0A000002, 4'b0000, 20'h00019, 3, 1, 0, 0};  // BEQ taken
        tbl[4]  = '{32'h15821004, 4'b0000, 20'h00125, 4, 0, 0, 0};  // STRNE, fails
        tbl[5]  = '{32'hE5821004, 4'b0000, 20'h00125, 4, 0, 0, 1};  // STR
        tbl[6]  = '{32'hE2521001, 4'b0010, 20'h00178, 4, 0, 1, 0};  // SUBS -> Z=0
        tbl[7]  = '{32'h0A000002, 4'b0000, 20'h00019, 3, 0, 0, 0};  // BEQ not taken
        tbl[8]  = '{32'hE1520003, 4'b0110, 20'h00168, 4, 0, 0, 0};  // CMP R2,R3 (Z=1 from ALU)
        tbl[9]  = '{32'h0A000002, 4'b0000, 20'h00019, 3, CMP_EN, 0, 0};  // BEQ sees CMP flags
        tbl[10] = '{32'hFE000000, 4'b1111, 20'h0001A, 3, 0, 0, 0};  // undefined class
        tbl[11] = '{32'hE281F004, 4'b0000, 20'h00178, 4, 1, 1, 0};  // ADD PC,R1,#4

        // Reset held: all outputs low, state FETCH
        rst = 1'b0;
        Instruction = 32'hE5921004;
        ALUFlags = 4'hF;
        m_flags = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_instr("table", tbl[i].ins, tbl[i].af, -1, sts, len, pcw, rw, mw);
            checks++;
            if (sts !== tbl[i].sts || len != tbl[i].len || pcw !== tbl[i].pcw ||
                rw !== tbl[i].rw || mw !== tbl[i].mw) begin
                errors++;
                $display("FAIL table[%0d] ins=%08h: got states=%05h len=%0d pcw/rw/mw=%b%b%b, want states=%05h len=%0d pcw/rw/mw=%b%b%b",
                         i, tbl[i].ins, sts, len, pcw, rw, mw,
                         tbl[i].sts, tbl[i].len, tbl[i].pcw, tbl[i].rw, tbl[i].mw);
            end
        end

        // Reset pulsed during MEMRD of an LDR, after Z has been set
        run_instr("subs_z", 32'hE2521001, 4'b0110, -1, sts, len, pcw, rw, mw);
        run_instr("ldr_rst", 32'hE5921004, 4'b0000, 3, sts, len, pcw, rw, mw);
        rst = 1'b0;
        #1;
        check_zero("rst_in_memrd");
        @(posedge clk);
        #1;
        check_zero("rst_held_edge");
        @(negedge clk);
        rst = 1'b1;
        m_flags = 4'h0;
        run_instr("beq_after_rst", 32'h0A000002, 4'b0000, -1, sts, len, pcw, rw, mw);
        checks++;
        if (pcw !== 1'b0) begin
            errors++;
            $display("FAIL beq_after_rst: got PCWrite=%b, want 0 (flags cleared)", pcw);
        end

        // Random instructions against the model
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010;
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[24:21] = cmds[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) != 0) ins[31:28] = 4'(i % 16);
            run_instr("rand", ins, 4'($urandom_range(0, 15)), -1, sts, len, pcw, rw, mw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
